dmem_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (program loader / debug access). Each cycle it grants at most one request, drives the memory's address, write-data, write-enable and read-enable, and returns read data one cycle later on a registered response. Optional lock support lets a requester hold the memory for back-to-back read-modify-write sequences.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Ownership states, port indices and the address-fault constants.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_state_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int         WORD_SHIFT = 2;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker; the port not granted last wins a tie.
// The mask input removes a port from consideration (used by ownership).
module dmem_arbiter_rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic       last_q;
  logic       last_d;
  logic [1:0] elig;

  always_comb begin
    elig = req & mask;
    if (elig == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    last_d = last_q;
    if (gnt[PORT0]) begin
      last_d = 1'b0;
    end else if (gnt[PORT1]) begin
      last_d = 1'b1;
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with registered response.
// Define DMEM_ARB_LOCK_EN to honour pN_lock (ownership for read-modify-write).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [1:0]        req_v;
  logic [1:0]        mask;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              we_s;
  logic              fault_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;

  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // No grants while reset is held, so the memory side stays quiet.
  assign req_v = {p1_req, p0_req} & {2{reset_n}};

  dmem_arbiter_rr_arb2 u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req_v),
    .mask   (mask),
    .gnt    (gnt)
  );

`ifdef DMEM_ARB_LOCK_EN
  own_state_e own_q, own_d;

  always_comb begin
    case (own_q)
      OWN0:    mask = 2'b01;
      OWN1:    mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  always_comb begin
    own_d = own_q;
    case (own_q)
      IDLE: begin
        if (gnt[PORT0] && p0_lock) begin
          own_d = OWN0;
        end else if (gnt[PORT1] && p1_lock) begin
          own_d = OWN1;
        end
      end
      OWN0:    if (!p0_lock && (gnt[PORT0] || !p0_req)) own_d = IDLE;
      OWN1:    if (!p1_lock && (gnt[PORT1] || !p1_req)) own_d = IDLE;
      default: own_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_q <= IDLE;
    end else begin
      own_q <= own_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = p0_lock ^ p1_lock;
  assign mask        = 2'b11;
`endif

  always_comb begin
    any_gnt = |gnt;
    we_s    = gnt[PORT1] ? p1_we    : p0_we;
    addr_s  = gnt[PORT1] ? p1_addr  : p0_addr;
    wdata_s = gnt[PORT1] ? p1_wdata : p0_wdata;
    fault_s = ((addr_s[1:0] & ALIGN_MASK) != 2'b00) || ((addr_s >> WORD_SHIFT) >= DEPTH_A);

    mem_addr  = any_gnt ? (addr_s >> WORD_SHIFT) : '0;
    mem_wdata = any_gnt ? wdata_s : '0;
    mem_we    = any_gnt && !fault_s && we_s;
    mem_re    = any_gnt && !fault_s && !we_s;

    rvalid_d = gnt;
    rdata_d  = (any_gnt && !fault_s && !we_s) ? mem_rdata : '0;
    err_d    = any_gnt && fault_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign p0_gnt    = gnt[PORT0];
  assign p1_gnt    = gnt[PORT1];
  assign p0_rvalid = rvalid_q[PORT0];
  assign p1_rvalid = rvalid_q[PORT1];
  assign p0_rdata  = rvalid_q[PORT0] ? rdata_q : '0;
  assign p1_rdata  = rvalid_q[PORT1] ? rdata_q : '0;
  assign p0_err    = rvalid_q[PORT0] & err_q;
  assign p1_err    = rvalid_q[PORT1] & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases with literal expectations, then random traffic
// checked every cycle against a behavioural model (grant choice, memory contents, responses).
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        we = '0;
  logic [1:0]        lock = '0;
  logic [31:0]       addr [2];
  logic [31:0]       wdata [2];
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0]       p0_rdata, p1_rdata;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_we, mem_re;
  logic              mem_init = 1'b0;
  logic [31:0]       mem [DEPTH];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_lock(lock[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_lock(lock[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // The memory the arbiter drives.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i) * 32'h9E37_79B9;
    end else if (mem_we && mem_addr < DEPTH) begin
      mem[mem_addr[8:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[8:0]] : 32'h0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [31:0] ref_mem [DEPTH];
  int          m_last = 1;
  int          m_owner = -1;
  int          m_rsp_port = -1;
  logic [31:0] m_rsp_data = '0;
  logic        m_rsp_err = 1'b0;
  int          m_win = -1;

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic bit may_grant(input int n);
`ifdef DMEM_ARB_LOCK_EN
    return (m_owner < 0) || (m_owner == n);
`else
    return (n >= 0);
`endif
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_owner = -1;
    m_rsp_port = -1;
    m_win = -1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Called at posedge+4: compare DUT with model, advance model, move to posedge+1.
  task automatic tick();
    bit w0, w1, flt;
    int win;
    logic [31:0] idx;
    w0 = reset_n && req[0] && may_grant(0);
    w1 = reset_n && req[1] && may_grant(1);
    win = -1;
    if (w0 && w1) win = 1 - m_last;
    else if (w0) win = 0;
    else if (w1) win = 1;
    flt = (win >= 0) && is_fault(addr[win]);

    chk("p0_gnt", p0_gnt, win == 0);
    chk("p1_gnt", p1_gnt, win == 1);
    chk("mem_we", mem_we, (win >= 0) && !flt && we[win]);
    chk("mem_re", mem_re, (win >= 0) && !flt && !we[win]);
    chk("mem_addr", mem_addr, (win >= 0) ? addr[win] / 4 : 32'h0);
    chk("mem_wdata", mem_wdata, (win >= 0) ? wdata[win] : 32'h0);
    chk("p0_rvalid", p0_rvalid, m_rsp_port == 0);
    chk("p1_rvalid", p1_rvalid, m_rsp_port == 1);
    if (m_rsp_port == 0) begin
      chk("p0_rdata", p0_rdata, m_rsp_data);
      chk("p0_err", p0_err, m_rsp_err);
    end else if (m_rsp_port == 1) begin
      chk("p1_rdata", p1_rdata, m_rsp_data);
      chk("p1_err", p1_err, m_rsp_err);
    end

    if (reset_n) begin
      m_rsp_port = win;
      if (win >= 0) begin
        idx = addr[win] / 4;
        m_rsp_err  = flt;
        m_rsp_data = (!flt && !we[win]) ? ref_mem[idx[8:0]] : 32'h0;
        if (!flt && we[win]) ref_mem[idx[8:0]] = wdata[win];
        m_last = win;
      end
`ifdef DMEM_ARB_LOCK_EN
      if (m_owner < 0) begin
        if (win >= 0 && lock[win]) m_owner = win;
      end else if (!lock[m_owner] && (win == m_owner || !req[m_owner])) begin
        m_owner = -1;
      end
`endif
    end else begin
      model_reset();
    end
    m_win = win;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit l);
    req[n] = r; we[n] = w; addr[n] = a; wdata[n] = d; lock[n] = l;
  endtask

  function automatic logic [31:0] gen_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom;
    if (r == 1) return (32'($urandom_range(0, DEPTH + 3)) << 2) | 32'($urandom_range(1, 3));
    if (r < 9) return 32'($urandom_range(0, 15)) << 2;
    return 32'($urandom_range(0, DEPTH + 2)) << 2;
  endfunction

  initial begin
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;
    mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    model_reset();

    // Reset state.
    settle();
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_err", p1_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    reset_n = 1'b1;
    settle();
    tick();

    // Write then read back on port 0.
    drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    settle();
    chk("wr_gnt", p0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h4);
    tick();
    drive(0, 1, 0, 32'h10, 32'h0, 0);
    settle();
    chk("rd_mem_re", mem_re, 1);
    chk("wr_rsp_rvalid", p0_rvalid, 1);
    tick();
    req[0] = 1'b0;
    settle();
    chk("rd_rvalid", p0_rvalid, 1);
    chk("rd_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_err", p0_err, 0);
    tick();

    // Fresh reset, then both ports contend for six cycles.
    reset_n = 1'b0;
    model_reset();
    settle();
    tick();
    reset_n = 1'b1;
    drive(0, 1, 0, 32'h40, 32'h0, 0);
    drive(1, 1, 0, 32'h44, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("alt_p0_gnt", p0_gnt, (i % 2) == 0);
      chk("alt_p1_gnt", p1_gnt, (i % 2) == 1);
      if (i > 0) chk("alt_rvalid", ((i - 1) % 2 == 0) ? p0_rvalid : p1_rvalid, 1);
      tick();
    end
    req = '0;
    settle();
    tick();

    // Faulting accesses on port 1.
    drive(1, 1, 0, 32'h801, 32'h0, 0);
    settle();
    chk("mis_gnt", p1_gnt, 1);
    chk("mis_mem_re", mem_re, 0);
    tick();
    drive(1, 1, 0, 32'h800, 32'h0, 0);
    settle();
    chk("mis_err", p1_err, 1);
    chk("mis_rdata", p1_rdata, 0);
    chk("oor_gnt", p1_gnt, 1);
    chk("oor_mem_re", mem_re, 0);
    tick();
    req[1] = 1'b0;
    settle();
    chk("oor_err", p1_err, 1);
    chk("oor_rdata", p1_rdata, 0);
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Port 1 locks for a read-modify-write while port 0 waits.
    drive(0, 1, 1, 32'h30, 32'h55, 0);
    settle();
    tick();
    drive(0, 1, 0, 32'h24, 32'h0, 0);
    drive(1, 1, 0, 32'h20, 32'h0, 1);
    settle();
    chk("lk_p1_gnt", p1_gnt, 1);
    chk("lk_p0_gnt_a", p0_gnt, 0);
    tick();
    drive(1, 1, 1, 32'h20, 32'h12345678, 0);
    settle();
    chk("lk_p0_gnt_b", p0_gnt, 0);
    chk("lk_p1_wr", p1_gnt, 1);
    tick();
    req[1] = 1'b0;
    settle();
    chk("lk_p0_gnt_c", p0_gnt, 1);
    tick();
    req = '0;
    lock = '0;
    settle();
    tick();
`endif

    // Reset right after a grant discards the pending response.
    drive(0, 1, 0, 32'h10, 32'h0, 0);
    settle();
    tick();
    reset_n = 1'b0;
    req = '0;
    model_reset();
    settle();
    chk("mid_rvalid", p0_rvalid, 0);
    chk("mid_rdata", p0_rdata, 0);
    chk("mid_mem_re", mem_re, 0);
    tick();
    reset_n = 1'b1;
    settle();
    chk("post_rvalid", p0_rvalid, 0);
    tick();

    // Random traffic; a port holds its request until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n] || m_win == n) begin
          drive(n, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, gen_addr(),
                $urandom, $urandom_range(0, 3) == 0);
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        req = '0;
        model_reset();
        settle();
        tick();
        reset_n = 1'b1;
      end
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
